// File: rtl/icache_refill_ctrl.sv
// Direct-mapped I-cache tag/valid store and line-refill sequencer.
// Optional hit/miss performance counters are built when ICACHE_PERF_CNT_EN is defined.
//
//   state  | meaning
//   IDLE   | combinational lookup; a miss latches the line and starts the refill
//   REFILL | one word per mem_valid into the data RAM; tag/valid set on the last word
module icache_refill_ctrl #(
    parameter int LINE_WORDS = 4,
    parameter int INDEX_BITS = 6,
    localparam int OFF_BITS  = $clog2(LINE_WORDS)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           cpu_req,
    input  logic [31:0]                    cpu_addr,
    output logic                           cpu_stall,
    output logic                           hit,
    output logic [INDEX_BITS+OFF_BITS-1:0] ram_raddr,
    output logic                           ram_we,
    output logic [INDEX_BITS+OFF_BITS-1:0] ram_waddr,
    output logic [31:0]                    ram_wdata,
    output logic                           mem_req,
    output logic [31:0]                    mem_addr,
    input  logic                           mem_valid,
    input  logic [31:0]                    mem_rdata,
    input  logic                           flush,
    output logic [31:0]                    hit_cnt,
    output logic [31:0]                    miss_cnt
);

    localparam int TAG_BITS = 30 - OFF_BITS - INDEX_BITS;
    localparam int NLINES   = 1 << INDEX_BITS;
    localparam logic [OFF_BITS-1:0] CNT_LAST = OFF_BITS'(LINE_WORDS - 1);

    typedef enum logic {
        IDLE,
        REFILL
    } state_t;

    state_t state_q, state_d;

    logic [OFF_BITS-1:0]   offset;
    logic [INDEX_BITS-1:0] index;
    logic [TAG_BITS-1:0]   tag;
    logic                  unused_addr_bits;

    logic [NLINES-1:0]     valid_q;
    logic [TAG_BITS-1:0]   tag_mem [NLINES];

    logic [TAG_BITS-1:0]   line_tag_q;
    logic [INDEX_BITS-1:0] line_idx_q;
    logic [OFF_BITS-1:0]   cnt_q;
    logic                  flush_pend_q;

    logic lookup_hit;
    logic start_refill;
    logic fill_done;

    assign offset           = cpu_addr[OFF_BITS+1:2];
    assign index            = cpu_addr[OFF_BITS+INDEX_BITS+1:OFF_BITS+2];
    assign tag              = cpu_addr[31:OFF_BITS+INDEX_BITS+2];
    assign unused_addr_bits = ^cpu_addr[1:0];

    assign ram_raddr  = {index, offset};
    assign lookup_hit = valid_q[index] && (tag_mem[index] == tag);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        hit          = 1'b0;
        cpu_stall    = 1'b0;
        mem_req      = 1'b0;
        mem_addr     = '0;
        ram_we       = 1'b0;
        ram_waddr    = '0;
        ram_wdata    = '0;
        start_refill = 1'b0;
        fill_done    = 1'b0;
        case (state_q)
            IDLE: begin
                hit       = cpu_req && lookup_hit;
                cpu_stall = cpu_req && !lookup_hit;
                if (cpu_req && !lookup_hit) begin
                    start_refill = 1'b1;
                    state_d      = REFILL;
                end
            end
            REFILL: begin
                mem_req   = 1'b1;
                cpu_stall = 1'b1;
                mem_addr  = {line_tag_q, line_idx_q, cnt_q, 2'b00};
                if (mem_valid) begin
                    ram_we    = 1'b1;
                    ram_waddr = {line_idx_q, cnt_q};
                    ram_wdata = mem_rdata;
                    if (cnt_q == CNT_LAST) begin
                        fill_done = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A flush seen during the refill wins over the valid-set of the line being filled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= '0;
            line_tag_q   <= '0;
            line_idx_q   <= '0;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            if (start_refill) begin
                line_tag_q <= tag;
                line_idx_q <= index;
                cnt_q      <= '0;
            end else if (ram_we) begin
                cnt_q <= cnt_q + 1'b1;
            end

            if (state_q == REFILL) begin
                if (fill_done) begin
                    flush_pend_q <= 1'b0;
                end else if (flush) begin
                    flush_pend_q <= 1'b1;
                end
            end

            if (fill_done) begin
                if (flush_pend_q || flush) begin
                    valid_q <= '0;
                end else begin
                    valid_q[line_idx_q] <= 1'b1;
                end
            end else if (state_q == IDLE && flush) begin
                valid_q <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill_done) begin
            tag_mem[line_idx_q] <= line_tag_q;
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (hit) begin
                hit_cnt <= hit_cnt + 32'd1;
            end
            if (start_refill) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Scoreboard bench for icache_refill_ctrl: stimulus queues expected lookups and
// line writes; a negedge monitor pops and compares them as the DUT presents them.
module tb_icache_refill_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic        flush = 1'b0;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_rdata;
    logic        cpu_stall, hit, ram_we, mem_req;
    logic [7:0]  ram_raddr, ram_waddr;
    logic [31:0] ram_wdata, mem_addr, hit_cnt, miss_cnt;

    icache_refill_ctrl dut (
        .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
        .cpu_stall(cpu_stall), .hit(hit), .ram_raddr(ram_raddr), .ram_we(ram_we),
        .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_valid(mem_valid), .mem_rdata(mem_rdata),
        .flush(flush), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    // backing memory returns address * 2
    assign mem_rdata = {mem_addr[30:0], 1'b0};

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] maddr;
        logic [7:0]  waddr;
        logic [31:0] wdata;
    } wr_t;

    wr_t wq[$];
    bit  lq[$];
    int  npass = 0;
    int  ntotal = 0;
    bit  exp_hit;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fail(input string name);
        ntotal++;
        $display("FAIL %s: event with nothing expected", name);
    endtask

    task automatic push_hit();
        lq.push_back(1'b1);
    endtask

    task automatic push_words(input logic [31:0] a, input int nwords);
        for (int i = 0; i < nwords; i++) begin
            wr_t w;
            w.maddr = {a[31:4], 4'h0} + 32'(4 * i);
            w.waddr = {a[9:4], 2'(i)};
            w.wdata = w.maddr * 2;
            wq.push_back(w);
        end
    endtask

    task automatic push_miss(input logic [31:0] a);
        lq.push_back(1'b0);
        push_words(a, 4);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("ram_raddr", {24'h0, ram_raddr}, {24'h0, cpu_addr[9:2]});
            if (mem_req) begin
                chk("refill_stall", cpu_stall, 1'b1);
                chk("refill_hit", hit, 1'b0);
                if (wq.size() == 0) begin
                    fail("unexpected_refill");
                end else begin
                    chk("mem_addr", mem_addr, wq[0].maddr);
                    if (ram_we) begin
                        chk("ram_waddr", {24'h0, ram_waddr}, {24'h0, wq[0].waddr});
                        chk("ram_wdata", ram_wdata, wq[0].wdata);
                        void'(wq.pop_front());
                    end
                end
            end else begin
                chk("idle_we", ram_we, 1'b0);
                if (cpu_req) begin
                    if (lq.size() == 0) begin
                        fail("unexpected_lookup");
                    end else begin
                        exp_hit = lq.pop_front();
                        chk("hit", hit, exp_hit);
                        chk("stall", cpu_stall, !exp_hit);
                    end
                end else begin
                    chk("noreq_hit", hit, 1'b0);
                    chk("noreq_stall", cpu_stall, 1'b0);
                end
            end
        end
    end

    // Drives one access until the fetch is released; mem_valid fires when k % period == period-1.
    task automatic run(input int period, input int chg_at, input logic [31:0] chg_addr,
                       input int flush_at, output int cycles);
        int k = 0;
        bit done = 0;
        cycles = 0;
        flush = (flush_at == 0);
        mem_valid = ((k % period) == (period - 1));
        while (!done && k < 200) begin
            @(negedge clk);
            done = !cpu_stall;
            cycles++;
            @(posedge clk);
            #1;
            k++;
            flush = (k == flush_at);
            if (k == chg_at) cpu_addr = chg_addr;
            mem_valid = ((k % period) == (period - 1));
        end
        cpu_req = 1'b0;
        flush = 1'b0;
        mem_valid = 1'b0;
        if (!done) fail("run_timeout");
    endtask

    task automatic access(input logic [31:0] a, input int period, input int flush_at,
                          output int cycles);
        cpu_addr = a;
        cpu_req = 1'b1;
        run(period, -1, 32'h0, flush_at, cycles);
    endtask

    initial begin
        int cyc;
        #2;
        chk("rst_stall", cpu_stall, 1'b0);
        chk("rst_hit", hit, 1'b0);
        chk("rst_we", ram_we, 1'b0);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_waddr", {24'h0, ram_waddr}, 32'h0);
        chk("rst_wdata", ram_wdata, 32'h0);
        chk("rst_hit_cnt", hit_cnt, 32'h0);
        chk("rst_miss_cnt", miss_cnt, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // cold miss: mem_addr 0x40..0x4C, ram_waddr 0x10..0x13, 6-cycle stall window
        push_miss(32'h40); push_hit();
        access(32'h40, 1, -1, cyc);
        chk("cold_miss_cycles", cyc, 6);

        // same line hits, then next line misses
        push_hit(); access(32'h48, 1, -1, cyc);
        push_hit(); access(32'h4C, 1, -1, cyc);
        chk("hit_cycles", cyc, 1);
        push_miss(32'h50); push_hit(); access(32'h50, 1, -1, cyc);

        // conflict on index 4
        push_miss(32'h440); push_hit(); access(32'h440, 1, -1, cyc);
        push_miss(32'h40); push_hit(); access(32'h40, 1, -1, cyc);

        // flush in IDLE: same-cycle lookup still hits, the next one misses
        push_hit(); access(32'h40, 1, 0, cyc);
        push_miss(32'h40); push_hit(); access(32'h40, 1, -1, cyc);

        // flush during refill leaves the refilled line invalid
        push_miss(32'h440); push_miss(32'h440); push_hit();
        access(32'h440, 1, 1, cyc);

        // backpressure plus address change mid-refill: 0x40 completes, then 0x200 misses
        push_miss(32'h40); push_miss(32'h200); push_hit();
        cpu_addr = 32'h40;
        cpu_req = 1'b1;
        run(3, 2, 32'h200, -1, cyc);

        // reset after two words of a refill
        cpu_addr = 32'h80;
        cpu_req = 1'b1;
        mem_valid = 1'b1;
        lq.push_back(1'b0);
        push_words(32'h80, 2);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        cpu_req = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_mem_req", mem_req, 1'b0);
        chk("midrst_stall", cpu_stall, 1'b0);
        chk("midrst_we", ram_we, 1'b0);
        chk("midrst_words_left", wq.size(), 0);
        mem_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // three misses and five hits after reset
        push_miss(32'h80); push_hit(); access(32'h80, 1, -1, cyc);
        push_miss(32'h90); push_hit(); access(32'h90, 1, -1, cyc);
        push_miss(32'hA0); push_hit(); access(32'hA0, 1, -1, cyc);
        push_hit(); access(32'h84, 1, -1, cyc);
        push_hit(); access(32'h94, 1, -1, cyc);
`ifdef ICACHE_PERF_CNT_EN
        chk("miss_cnt", miss_cnt, 32'd3);
        chk("hit_cnt", hit_cnt, 32'd5);
`else
        chk("miss_cnt_tied", miss_cnt, 32'd0);
        chk("hit_cnt_tied", hit_cnt, 32'd0);
`endif

        repeat (2) @(posedge clk);
        chk("lookups_drained", lq.size(), 0);
        chk("writes_drained", wq.size(), 0);
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule

// File: doc/icache_refill_ctrl.md
# icache_refill_ctrl

Miss-handling controller for the direct-mapped instruction cache. Holds the tag/valid store, decides hit/miss for each fetch address, and stalls the fetch stage on a miss. On a miss it sequences a full-line refill from backing instruction memory into the cache data RAM write port, one word per memory handshake. Sits between the fetch stage and the instruction cache data array and memory.

## Interface
- `LINE_WORDS`, 4: words per line; must be a power of 2 and at least 2. `OFF_BITS` = log2(`LINE_WORDS`).
- `INDEX_BITS`, 6: line index width, giving 64 lines.
- `clk` input 1: clock; all state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `cpu_req` input 1: fetch request valid.
- `cpu_addr` input 32: byte fetch address; bits [1:0] ignored.
- `cpu_stall` output 1: fetch must hold `cpu_addr`.
- `hit` output 1: lookup hit this cycle.
- `ram_raddr` output INDEX_BITS+OFF_BITS: data RAM read address, {index, offset} of `cpu_addr`.
- `ram_we` output 1: data RAM write enable.
- `ram_waddr` output INDEX_BITS+OFF_BITS: data RAM write address.
- `ram_wdata` output 32: data RAM write data.
- `mem_req` output 1: backing memory read request.
- `mem_addr` output 32: word-aligned memory read address.
- `mem_valid` input 1: memory returns `mem_rdata` this cycle.
- `mem_rdata` input 32: memory read data.
- `flush` input 1: invalidate all lines.
- `hit_cnt` output 32: hit counter. Present only with `ICACHE_PERF_CNT_EN`.
- `miss_cnt` output 32: miss counter. Present only with `ICACHE_PERF_CNT_EN`.

## Operation
- Address split:
  - offset = `cpu_addr`[OFF_BITS+1:2].
  - index = next INDEX_BITS bits.
  - tag = the remaining upper bits.
- Tag/valid store: a register array of `2^INDEX_BITS` entries. Reset clears all valid bits. Tags are not reset.
- FSM states are IDLE and REFILL.
- IDLE:
  - `hit` = `cpu_req` & valid[index] & (tag[index] == tag). This is combinational.
  - `cpu_stall` = `cpu_req` & !`hit`.
  - On a miss, latch the line base = {tag, index, OFF_BITS'b0, 2'b0}, clear the word counter, and go to REFILL.
- REFILL:
  - `mem_req` = 1, `mem_addr` = line base + counter*4, `cpu_stall` = 1, `hit` = 0.
  - `cpu_addr` is ignored; the latched address governs.
  - On `mem_valid`: `ram_we` = 1, `ram_waddr` = {latched index, counter}, `ram_wdata` = `mem_rdata`, then the counter increments.
  - On `mem_valid` with counter = `LINE_WORDS`-1: write the tag, set the valid bit, and return to IDLE.
  - A line is never marked valid on a partial fill.
- `ram_raddr` always follows `cpu_addr`.
- `ram_we` is 0 in every case other than the REFILL write described above.
- Flush:
  - In IDLE with `flush`=1, all valid bits clear at the edge. The lookup in that same cycle still uses the pre-flush contents.
  - A flush during REFILL is latched and applied on the cycle the FSM re-enters IDLE. It takes priority over the line's valid-set, so the refilled line ends up invalid.
- Reset mid-refill: the FSM goes to IDLE immediately and `mem_req` drops asynchronously. The partial line stays invalid.
- Reset values:
  - `cpu_stall`, `hit`, `ram_we`, `mem_req` = 0.
  - `mem_addr`, `ram_waddr`, `ram_wdata` = 0.
  - `hit_cnt`, `miss_cnt` = 0.

## Timing
- Hit: 0-cycle decision; `hit` is valid in the same cycle as `cpu_req`.
- Miss penalty: 1 cycle (IDLE to REFILL) plus the memory cycles for `LINE_WORDS` handshakes. After REFILL exits, the next IDLE cycle hits and `cpu_stall` falls.
- With `mem_valid` tied high, a 4-word line stalls for 6 cycles: the miss cycle, 4 REFILL cycles, and then the hit cycle, in which `cpu_stall` is 0.
- `mem_req` stays asserted continuously through REFILL. `mem_addr` changes only on the edge after a `mem_valid`.
- Counter and tag widths are exact. The counter wraps only on leaving REFILL.

## Configuration
- `ICACHE_PERF_CNT_EN` defined:
  - `hit_cnt` increments on every IDLE cycle with `hit`=1.
  - `miss_cnt` increments on every IDLE-to-REFILL transition.
  - Both are 32-bit and wrap at 2^32.
  - Both are cleared only by reset, not by `flush`.
- `ICACHE_PERF_CNT_EN` undefined: no counter logic is built, and `hit_cnt` and `miss_cnt` are tied to 0.

## Test plan
- **Cold miss:** reset, `cpu_req`=1, `cpu_addr`=0x40, `mem_valid`=1, memory returns addr*2.
  - `mem_addr` steps 0x40, 0x44, 0x48, 0x4C.
  - `ram_waddr` steps 0x10..0x13.
  - On the next cycle `hit`=1 and `cpu_stall`=0.
- **Same line, other word:** 0x48 then 0x4C after a fill → `hit`=1 each cycle with no `mem_req`. 0x50 → miss.
- **Conflict:** fill 0x40, then 0x440 (same index, different tag) → miss and refill; then 0x40 → miss again.
- **Memory backpressure:** `mem_valid` pulses every 3rd cycle → `mem_addr` holds between pulses, and `ram_we` fires only on the pulses. `cpu_addr` changed mid-refill to 0x200 → the refill completes for 0x40.
- **Flush:**
  - Flush in IDLE after a fill of 0x40 → the next lookup of 0x40 misses.
  - Flush during REFILL → the refilled line is invalid and the re-request misses.
- **Reset mid-refill, counters (`ICACHE_PERF_CNT_EN`):**
  - `rst_n`=0 after 2 words → `mem_req`=0 immediately; a re-request of the same line misses.
  - Sequence of 3 misses and 5 hits → `miss_cnt`=3, `hit_cnt`=5.
